// File: rtl/qconv2d_requant_stream.sv
// qconv2d_requant_stream
//   Captures one wide-accumulator output tensor of qconv2d in a single
//   valid/ready transaction, then streams it out one spatial pixel per beat
//   (row-major n, h, w with w fastest). Every beat carries all YC channels,
//   requantised to OB bits: round-half-up arithmetic right shift by SHIFT,
//   optional ReLU, then saturation to the signed OB-bit range.
//
// Optional feature macro:
//   QREQUANT_RELU_EN  defined   -> negative shifted values are clamped to 0
//                     undefined -> negative values go straight to saturation
//
// Ports:
//   clk      in   single clock
//   rstn     in   synchronous active-low reset
//   s_valid  in   input tensor valid
//   s_ready  out  block can capture a tensor (IDLE)
//   s_data   in   [YN][YH][YW][YC][YB] tensor, packed as qconv2d.y
//   m_valid  out  output beat valid (STREAM)
//   m_ready  in   downstream accepts the beat
//   m_data   out  [YC][OB] one requantised pixel
//   m_last   out  high on the final beat of a tensor
module qconv2d_requant_stream #(
  parameter int YN    = 1,
  parameter int YH    = 4,
  parameter int YW    = 4,
  parameter int YC    = 8,
  parameter int YB    = 21,
  parameter int OB    = 11,
  parameter int SHIFT = 6
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  input  logic [YN-1:0][YH-1:0][YW-1:0][YC-1:0][YB-1:0] s_data,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic [YC-1:0][OB-1:0]                        m_data,
  output logic                                         m_last
);

  localparam int NPIX = YN * YH * YW;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [PW-1:0] LAST_P = PW'(NPIX - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  // Rounding bias 2^(SHIFT-1), or 0 when SHIFT is 0.
  localparam logic signed [YB:0] RND  = (YB+1)'((64'd1 << SHIFT) >> 1);
  localparam logic signed [YB:0] MAXV = (YB+1)'((64'sd1 <<< (OB - 1)) - 64'sd1);
  localparam logic signed [YB:0] MINV = -MAXV - (YB+1)'(1);

  logic [0:0]                          r_state;
  logic [PW-1:0]                       r_p;
  logic [NPIX-1:0][YC-1:0][YB-1:0]     r_buf;
  logic [YC-1:0][OB-1:0]               r_data;
  logic                                r_last;

  logic [NPIX-1:0][YC-1:0][YB-1:0]     w_in;
  logic                                w_cap;
  logic                                w_beat;
  logic                                w_at_last;
  logic [PW-1:0]                       w_p_next;
  logic [YC-1:0][OB-1:0]               w_req_first;
  logic [YC-1:0][OB-1:0]               w_req_next;

  // Element requantisation at YB+1 bits so adding the bias cannot overflow.
  function automatic logic [OB-1:0] requant(input logic [YB-1:0] a);
    logic signed [YB:0] v;
    v = $signed({a[YB-1], a}) + RND;
    v = v >>> SHIFT;
`ifdef QREQUANT_RELU_EN
    if (v < 0) v = '0;
`endif
    if (v > MAXV)      v = MAXV;
    else if (v < MINV) v = MINV;
    return v[OB-1:0];
  endfunction

  // Tensor layout with n,h,w collapsed: pixel index p = (n*YH + h)*YW + w.
  assign w_in      = s_data;
  assign w_cap     = (r_state == S_IDLE) && s_valid;
  assign w_beat    = (r_state == S_STREAM) && m_ready;
  assign w_at_last = (r_p == LAST_P);
  // Saturating next index keeps the buffer read in range on the final beat.
  assign w_p_next  = w_at_last ? r_p : r_p + PW'(1);

  // Beat 0 is requantised straight from s_data so it is ready one cycle
  // after capture; later beats are prefetched from the buffer.
  for (genvar gi = 0; gi < YC; gi++) begin : g_req
    assign w_req_first[gi] = requant(w_in[0][gi]);
    assign w_req_next[gi]  = requant(r_buf[w_p_next][gi]);
  end

  // Tensor buffer: written only on the input handshake, no reset needed.
  always_ff @(posedge clk) begin
    if (w_cap) r_buf <= w_in;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s_valid) begin
            r_p     <= '0;
            r_data  <= w_req_first;
            r_last  <= (NPIX == 1);
            r_state <= S_STREAM;
          end
        end
        default: begin
          if (w_beat) begin
            if (w_at_last) begin
              r_last  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_p    <= w_p_next;
              r_data <= w_req_next;
              r_last <= (w_p_next == LAST_P);
            end
          end
        end
      endcase
    end
  end

  assign s_ready = (r_state == S_IDLE);
  assign m_valid = (r_state == S_STREAM);
  assign m_data  = r_data;
  assign m_last  = r_last;

endmodule

// File: doc/qconv2d_requant_stream.md
# qconv2d_requant_stream

Downstream stage of `qconv2d`. Captures one complete wide-accumulator output tensor `y` in a single valid/ready transaction, then serialises it one spatial pixel per beat over a valid/ready stream. Each beat carries all `YC` channels, requantised back to activation width (rounding right shift, optional ReLU, saturation). The stream feeds the next layer's input loader or the host DMA.

## Interface
Parameters:
- `YN`, default 1: batch count of the input tensor.
- `YH`, default 4: output height.
- `YW`, default 4: output width.
- `YC`, default 8: output channels.
- `YB`, default 21: accumulator width of `s_data` elements, signed.
- `OB`, default 11: requantised element width, signed; matches the next layer's `XB`.
- `SHIFT`, default 6: arithmetic right shift, 0..YB-1; equals the weight fractional bits.

Ports:
- `clk`, in, 1: the single clock.
- `rstn`, in, 1: synchronous, active-low reset.
- `s_valid`, in, 1: input tensor valid.
- `s_ready`, out, 1: block can capture a tensor.
- `s_data`, in, `[YN-1:0][YH-1:0][YW-1:0][YC-1:0][YB-1:0]`: input tensor, packed exactly as `qconv2d.y`.
- `m_valid`, out, 1: output beat valid.
- `m_ready`, in, 1: downstream accepts the beat.
- `m_data`, out, `[YC-1:0][OB-1:0]`: one pixel, all channels, requantised.
- `m_last`, out, 1: high on the final beat of a tensor.

## Operation
- FSM states: IDLE and STREAM.
- IDLE:
  - `s_ready`=1.
  - On `s_valid && s_ready`, register `s_data` into the tensor buffer, clear the pixel counter `p` to 0, and go to STREAM.
- STREAM:
  - `s_ready`=0.
  - `m_valid`=1; `m_data` = requant(buffer pixel `p`).
  - Pixel order is row-major n, h, w, with w fastest; `p` ranges 0..YN*YH*YW-1.
  - On `m_valid && m_ready`:
    - if `p` is the last pixel, go to IDLE;
    - otherwise `p` <= `p`+1.
  - `m_last` = (`p` == YN*YH*YW-1) && `m_valid`.
- Requant per element `a`, computed at signed width YB+1:
  - `r` = (`a` + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT. This is round half up, i.e. floor of (a/2^SHIFT + 0.5).
  - Optionally ReLU, see Configuration.
  - Saturate `r` to [-2^(OB-1), 2^(OB-1)-1].
- `m_data` and `m_last` come from an output register. While `m_valid && !m_ready`, `m_data` and `m_last` are held stable.
- The buffer is written only in IDLE on handshake. A `s_valid` arriving during STREAM is not captured; upstream holds it until `s_ready` rises.

## Timing
- Reset (`rstn`=0 at a clk edge) forces the following from the next cycle:
  - state IDLE, `p`=0;
  - `s_ready`=1, `m_valid`=0, `m_last`=0, `m_data`=0.
- Reset mid-stream abandons the tensor; no further beats are emitted for it.
- Latency: capture at edge T, so beat 0 has `m_valid`=1 from cycle T+1.
- Throughput:
  - With `m_ready` held high, one beat per cycle.
  - YN*YH*YW beats per tensor, plus one IDLE cycle between tensors. The last-beat handshake at edge E gives `s_ready`=1 in cycle E+1.
- Combinational paths: no input-to-output combinational path. `s_ready` and `m_valid` are decoded from state registers only.
- Degenerate size: YN*YH*YW=1 means a single beat with `m_last`=1.

## Configuration
- `QREQUANT_RELU_EN` defined: after the shift, any `r` < 0 becomes 0. Output range is then [0, 2^(OB-1)-1].
- `QREQUANT_RELU_EN` undefined: no ReLU; negative values pass through to saturation.

## Test plan
- Rounding, defaults, ReLU off:
  - element 100 -> 2;
  - element -100 -> -2;
  - element 96 -> 2;
  - element 95 -> 1;
  - element 0 -> 0.
- Saturation:
  - 200000 -> 1023;
  - -200000 -> -1024;
  - with `QREQUANT_RELU_EN`, -200000 -> 0 and -100 -> 0.
- Ordering: load `s_data` with element value (pixel index × 64) for all channels, `m_ready`=1.
  - 16 beats carry `m_data` channels equal to 0, 1, …, 15.
  - `m_last` is high only on beat 15.
  - `s_ready` returns 1 on the cycle after beat 15.
- Backpressure: drop `m_ready` for 5 cycles while beat 3 is valid.
  - `m_data` and `m_last` stay stable throughout.
  - No beat is skipped or duplicated.
  - Total beats = 16.
- Overlap: assert `s_valid` continuously with a second tensor during streaming.
  - It is not captured until IDLE.
  - First tensor output is unchanged.
  - Second tensor beat 0 appears 2 cycles after the first tensor's last handshake.
- Reset mid-stream: pull `rstn` low during beat 7.
  - Next cycle: `m_valid`=0, `m_data`=0, `s_ready`=1.
  - After release, a new tensor streams from beat 0 correctly.
